// File: rtl/seq_divider.sv
// Multicycle signed restoring divider for DIV: one quotient bit per clock,
// sign fix-up in a final cycle, done/div0 pulses for the control unit.
module seq_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;
  logic [WIDTH:0]   shifted;

  // dvd_q holds the dividend magnitude and fills with quotient bits from the LSB
  // as it shifts, so after WIDTH iterations it is the unsigned quotient.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    acc_d    = acc_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    div0_d   = 1'b0;
    shifted  = {acc_q, dvd_q[WIDTH-1]};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            div0_d = 1'b1;
          end else begin
            dvd_d    = dividend[WIDTH-1] ? -dividend : dividend;
            dvs_d    = divisor[WIDTH-1]  ? -divisor  : divisor;
            sign_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sign_r_d = dividend[WIDTH-1];
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        if (shifted >= {1'b0, dvs_q}) begin
          acc_d = WIDTH'(shifted - {1'b0, dvs_q});
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = shifted[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        quot_d  = sign_q_q ? -dvd_q : dvd_q;
        rem_d   = sign_r_q ? -acc_q : acc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      acc_q    <= '0;
      quot_q   <= '0;
      rem_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      acc_q    <= acc_d;
      quot_q   <= quot_d;
      rem_q    <= rem_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign div0 = div0_q;
  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results,
// a negedge monitor pops and compares on every done/div0 pulse.
module tb_seq_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy, done, div0;
  logic [31:0] quot, rem;

  typedef struct {
    bit          is_div0;
    logic [31:0] q;
    logic [31:0] r;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .dividend(dividend),
    .divisor(divisor), .busy(busy), .done(done), .div0(div0),
    .quot(quot), .rem(rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: decoupled from stimulus, compares each response with the queue head.
  always @(negedge clk) begin
    if (reset === 1'b1 && (done === 1'b1 || div0 === 1'b1)) begin
      chk("done_div0_exclusive", {31'b0, done & div0}, 32'h0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_response: got done=%b div0=%b expected none", done, div0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_kind", {31'b0, div0}, {31'b0, e.is_div0});
        chk("quot", quot, e.q);
        chk("rem", rem, e.r);
      end
    end
  end

  task automatic issue_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Samples 1ns after each edge, starting right after the start edge.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0; busy_cnt = 0;
    while (done !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er);
    int lat, bc;
    sb.push_back('{1'b0, eq, er});
    issue_start(a, b);
    wait_done(lat, bc);
    chk("done_latency", lat, 32'd33);
    chk("busy_cycles", bc, 32'd33);
    @(posedge clk); #1;
    chk("done_one_cycle", {31'b0, done}, 32'h0);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_busy"}, {31'b0, busy}, 32'h0);
    chk({tag, "_done"}, {31'b0, done}, 32'h0);
    chk({tag, "_div0"}, {31'b0, div0}, 32'h0);
    chk({tag, "_quot"}, quot, 32'h0);
    chk({tag, "_rem"},  rem,  32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, bc, extra;
    reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    @(negedge clk); reset = 1'b1;

    run_div(32'd7, 32'd2, 32'h00000003, 32'h00000001);

    // Divide by zero: one-cycle div0, results untouched.
    sb.push_back('{1'b1, 32'h00000003, 32'h00000001});
    issue_start(32'd55, 32'd0);
    chk("div0_pulse", {31'b0, div0}, 32'h1);
    chk("div0_busy", {31'b0, busy}, 32'h0);
    chk("div0_done", {31'b0, done}, 32'h0);
    @(posedge clk); #1;
    chk("div0_clear", {31'b0, div0}, 32'h0);
    chk("div0_busy2", {31'b0, busy}, 32'h0);
    chk("div0_quot_hold", quot, 32'h00000003);
    chk("div0_rem_hold", rem, 32'h00000001);

    run_div(32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF);
    run_div(32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001);
    run_div(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);
    run_div(32'h80000000, 32'd1, 32'h80000000, 32'h00000000);
    run_div(32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE);
    run_div(32'd5, 32'd10, 32'd0, 32'd5);
    run_div(32'hFFFFFFFF, 32'h7FFFFFFF, 32'd0, 32'hFFFFFFFF);

    // Reset mid-operation abandons the division.
    issue_start(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check_idle_zero("midreset");
    @(negedge clk); reset = 1'b1;
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    chk("no_done_after_reset", extra, 32'd0);
    run_div(32'd100, 32'd7, 32'd14, 32'd2);

    // Start while busy and operand changes are ignored.
    sb.push_back('{1'b0, 32'd14, 32'd2});
    issue_start(32'd100, 32'd7);
    repeat (2) @(posedge clk);
    @(negedge clk); start = 1'b1; dividend = 32'd9; divisor = 32'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); dividend = 32'd12345; divisor = 32'd1;
    wait_done(lat, bc);
    chk("busy_start_done_seen", {31'b0, done}, 32'h1);
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) extra++;
    end
    chk("no_second_done", extra, 32'd0);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
